fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the single-issue RV32 core. Owns the program counter, drives the address of the combinational-read instruction memory, and registers the returned word together with its PC into an IF/ID output register. Delivery to decode uses a valid/ready handshake. Branch/jump redirects and fetch faults (misaligned or out-of-range PC) are handled here.

## Interface

Parameters:
- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- MEM_SIZE, 1024, instruction memory size in bytes; must be a multiple of 4
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc  out  XLEN  fetch address to instruction memory; equals the PC register
- inst  in  ILEN  instruction word from memory, combinationally valid for `pc` in the same cycle
- redirect_valid  in  1  redirect request from execute
- redirect_pc  in  XLEN  redirect target
- out_valid  out  1  IF/ID register holds an instruction
- out_ready  in  1  decode accepts this cycle
- out_inst  out  ILEN  registered instruction
- out_pc  out  XLEN  PC of out_inst
- out_fault  out  1  out_inst is a fault marker, not a real fetch
- fetch_count  out  32  number of non-fault instructions transferred to decode

## Operation

- State machine: RUN, HALT. Reset state is RUN.
- Transfer: `out_valid && out_ready`.
- Load condition: `load = !out_valid || out_ready`.
- Fault condition: `pc[1:0] != 0` or `pc > MEM_SIZE-4`, unsigned, XLEN-bit compare.
- Priority, highest first:
  1. **redirect_valid (any state):** pc <= redirect_pc; out_valid <= 0, flushing any held instruction even if not yet transferred; state <= RUN. A transfer occurring in the same cycle still counts.
  2. **RUN, load, no fault:** out_inst <= inst; out_pc <= pc; out_fault <= 0; out_valid <= 1; pc <= pc + 4 (wraps mod 2^XLEN).
  3. **RUN, load, fault:** out_inst <= 32'h00000013 (NOP); out_pc <= pc; out_fault <= 1; out_valid <= 1; pc unchanged; state <= HALT.
  4. **RUN, no load:** all registers hold. Output is stable while `out_valid && !out_ready`.
  5. **HALT:** no new loads. On transfer, out_valid <= 0. Otherwise hold. Stays in HALT until a redirect.
- fetch_count increments by 1 on each transfer with out_fault=0; wraps mod 2^32. It is not cleared by redirect.

## Timing

- Reset (async, immediate, no clock needed):
  - pc = RESET_PC
  - out_valid = 0, out_inst = 0, out_pc = 0, out_fault = 0
  - fetch_count = 0
  - state = RUN
- First out_valid = 1 after the first rising edge following reset_n deassertion. out_pc = RESET_PC.
- Throughput: 1 instruction/cycle with out_ready held high.
- Fetch-to-output latency: 1 cycle.
- Redirect penalty:
  - redirect in cycle N → out_valid = 0 in cycle N+1
  - target instruction valid in cycle N+2
- Reset asserted mid-stream: the in-flight instruction is discarded, with no partial update.
- out_pc and pc are never X after reset. `pc` changes only on clock edges.

## Test plan

1. **Sequential fetch.** Memory words at 0x0/0x4/0x8 = 0x00100093/0x00200113/0x00300193, RESET_PC=0, out_ready=1, release reset → out_valid=0 before the first edge; then out_pc 0x0, 0x4, 0x8 with matching out_inst on consecutive cycles; fetch_count=3 after the third transfer.
2. **Backpressure.** out_ready=0 for 3 cycles once out_pc=0x4 is valid → out_inst/out_pc stay at 0x4 entry and pc stays 0x8. Raise out_ready → 0x8 follows on the next cycle with no loss or duplication.
3. **Redirect with held instruction.** out_valid=1, out_pc=0x4, out_ready=0, redirect_valid=1, redirect_pc=0x40 → next cycle out_valid=0 and pc=0x40; following cycle out_pc=0x40. The 0x4 entry is never transferred and fetch_count is unchanged.
4. **Misaligned redirect.** redirect_pc=0x42 → out_fault=1, out_inst=0x00000013, out_pc=0x42. After transfer, out_valid=0 and stays 0 for ≥5 cycles with fetch_count unchanged. Redirect to 0x0 → fetching resumes at 0x0.
5. **Upper boundary.** MEM_SIZE=1024, sequential fetch from 0x3F8 → 0x3F8 and 0x3FC delivered with out_fault=0; 0x400 delivered with out_fault=1 and the block halts.
6. **Asynchronous reset.** Assert reset_n=0 mid-cycle while out_valid=1 → out_valid=0, pc=RESET_PC and fetch_count=0 immediately, before the next edge. Fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the single-issue RV32 core.
// Owns the PC, addresses the combinational instruction memory and delivers
// {inst, pc, fault} to decode through a valid/ready IF/ID register.
// A misaligned or out-of-range PC produces one fault-marked NOP and then the
// stage parks in HALT until execute redirects it.
module fetch_stage #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           ILEN     = 32,
  parameter int unsigned           MEM_SIZE = 1024,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [XLEN-1:0] pc,
  input  logic [ILEN-1:0] inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault,
  output logic [31:0]     fetch_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [XLEN-1:0] LAST_WORD = XLEN'(MEM_SIZE - 4);
  localparam logic [ILEN-1:0] NOP_INST  = ILEN'(32'h0000_0013);

  // Misaligned or beyond the last word of instruction memory (unsigned compare).
  function automatic logic fetch_fault(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr > LAST_WORD);
  endfunction

  state_t          state;
  logic [XLEN-1:0] pc_p0;
  logic            vld_p1;
  logic [ILEN-1:0] inst_p1;
  logic [XLEN-1:0] pc_p1;
  logic            fault_p1;
  logic [31:0]     fetch_cnt;

  logic xfer;
  logic load;
  logic fault_p0;

  assign xfer     = vld_p1 && out_ready;
  assign load     = !vld_p1 || out_ready;
  assign fault_p0 = fetch_fault(pc_p0);

  // Stage p0 -> p1: PC update, IF/ID register capture, redirect/halt control.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      pc_p0     <= RESET_PC;
      vld_p1    <= 1'b0;
      inst_p1   <= '0;
      pc_p1     <= '0;
      fault_p1  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      // A transfer completing in a redirect cycle still counts.
      if (xfer && !fault_p1)
        fetch_cnt <= fetch_cnt + 32'd1;

      if (redirect_valid) begin
        // Flush whatever is held, even if decode never took it.
        pc_p0  <= redirect_pc;
        vld_p1 <= 1'b0;
        state  <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (load) begin
              if (!fault_p0) begin
                inst_p1  <= inst;
                pc_p1    <= pc_p0;
                fault_p1 <= 1'b0;
                vld_p1   <= 1'b1;
                pc_p0    <= pc_p0 + XLEN'(4);
              end else begin
                // Deliver a single NOP marker carrying the bad PC, then park.
                inst_p1  <= NOP_INST;
                pc_p1    <= pc_p0;
                fault_p1 <= 1'b1;
                vld_p1   <= 1'b1;
                state    <= HALT;
              end
            end
          end
          HALT: begin
            if (xfer)
              vld_p1 <= 1'b0;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign pc          = pc_p0;
  assign out_valid   = vld_p1;
  assign out_inst    = inst_p1;
  assign out_pc      = pc_p1;
  assign out_fault   = fault_p1;
  assign fetch_count = fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, backpressure, redirect
// flush, misaligned-redirect fault/halt, upper memory boundary, async reset.
module tb_fetch_stage;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic [31:0] fetch_count;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:255];

  fetch_stage #(
    .XLEN     (32),
    .ILEN     (32),
    .MEM_SIZE (1024),
    .RESET_PC (32'h0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pc             (pc),
    .inst           (inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .fetch_count    (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational instruction memory model.
  always_comb begin
    inst = 32'hDEAD_BEEF;
    if (pc < 32'd1024)
      inst = mem[pc[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Assert reset away from any edge, release it before the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | (i << 2);
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0030_0193;

    // Reset state
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_fault", {31'b0, out_fault}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    #2 reset_n = 1'b1;
    #1;
    chk("pre_edge_valid", {31'b0, out_valid}, 32'h0);

    // 1. Sequential fetch
    tick();
    chk("seq0_valid", {31'b0, out_valid}, 32'h1);
    chk("seq0_pc", out_pc, 32'h0);
    chk("seq0_inst", out_inst, 32'h0010_0093);
    chk("seq0_nextpc", pc, 32'h4);
    tick();
    chk("seq1_pc", out_pc, 32'h4);
    chk("seq1_inst", out_inst, 32'h0020_0113);
    chk("seq1_count", fetch_count, 32'd1);
    tick();
    chk("seq2_pc", out_pc, 32'h8);
    chk("seq2_inst", out_inst, 32'h0030_0193);
    tick();
    chk("seq_count3", fetch_count, 32'd3);
    chk("seq3_pc", out_pc, 32'hC);

    // 2. Backpressure
    do_reset();
    tick();
    chk("bp0_pc", out_pc, 32'h0);
    tick();
    chk("bp1_pc", out_pc, 32'h4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_pc", out_pc, 32'h4);
      chk("bp_hold_inst", out_inst, 32'h0020_0113);
      chk("bp_hold_fpc", pc, 32'h8);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_hold_count", fetch_count, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_pc", out_pc, 32'h8);
    chk("bp_rel_inst", out_inst, 32'h0030_0193);
    chk("bp_rel_count", fetch_count, 32'd2);
    tick();
    chk("bp_next_pc", out_pc, 32'hC);
    chk("bp_next_count", fetch_count, 32'd3);

    // 3. Redirect with a held instruction
    do_reset();
    tick();
    tick();
    chk("rd_held_pc", out_pc, 32'h4);
    chk("rd_held_count", fetch_count, 32'd1);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", {31'b0, out_valid}, 32'h0);
    chk("rd_flush_pc", pc, 32'h40);
    chk("rd_flush_count", fetch_count, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("rd_tgt_valid", {31'b0, out_valid}, 32'h1);
    chk("rd_tgt_pc", out_pc, 32'h40);
    chk("rd_tgt_inst", out_inst, 32'hA000_0040);
    chk("rd_tgt_count", fetch_count, 32'd1);
    tick();
    chk("rd_seq_pc", out_pc, 32'h44);
    chk("rd_seq_count", fetch_count, 32'd2);

    // 4. Misaligned redirect (0x44 entry transfers in the redirect cycle)
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("mis_flush_valid", {31'b0, out_valid}, 32'h0);
    chk("mis_count_same_cycle", fetch_count, 32'd3);
    tick();
    chk("mis_valid", {31'b0, out_valid}, 32'h1);
    chk("mis_fault", {31'b0, out_fault}, 32'h1);
    chk("mis_inst", out_inst, 32'h0000_0013);
    chk("mis_pc", out_pc, 32'h42);
    chk("mis_fpc", pc, 32'h42);
    out_ready = 1'b1;
    tick();
    chk("mis_xfer_valid", {31'b0, out_valid}, 32'h0);
    chk("mis_xfer_count", fetch_count, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_valid", {31'b0, out_valid}, 32'h0);
      chk("halt_count", fetch_count, 32'd3);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("resume_fpc", pc, 32'h0);
    tick();
    chk("resume_valid", {31'b0, out_valid}, 32'h1);
    chk("resume_pc", out_pc, 32'h0);
    chk("resume_inst", out_inst, 32'h0010_0093);
    chk("resume_fault", {31'b0, out_fault}, 32'h0);

    // 5. Upper boundary
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3F8;
    tick();
    redirect_valid = 1'b0;
    chk("ub_redirect_count", fetch_count, 32'd4);
    tick();
    chk("ub0_pc", out_pc, 32'h3F8);
    chk("ub0_inst", out_inst, 32'hA000_03F8);
    chk("ub0_fault", {31'b0, out_fault}, 32'h0);
    tick();
    chk("ub1_pc", out_pc, 32'h3FC);
    chk("ub1_inst", out_inst, 32'hA000_03FC);
    chk("ub1_fault", {31'b0, out_fault}, 32'h0);
    tick();
    chk("ub2_pc", out_pc, 32'h400);
    chk("ub2_fault", {31'b0, out_fault}, 32'h1);
    chk("ub2_inst", out_inst, 32'h0000_0013);
    chk("ub2_count", fetch_count, 32'd6);
    tick();
    chk("ub_halt_valid", {31'b0, out_valid}, 32'h0);
    tick();
    chk("ub_halt_valid2", {31'b0, out_valid}, 32'h0);
    chk("ub_halt_count", fetch_count, 32'd6);

    // 6. Asynchronous reset mid-cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("ar_pre_pc", out_pc, 32'h4);
    chk("ar_pre_count", fetch_count, 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_fpc", pc, 32'h0);
    chk("ar_count", fetch_count, 32'h0);
    chk("ar_out_pc", out_pc, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("ar_restart_pc", out_pc, 32'h0);
    chk("ar_restart_valid", {31'b0, out_valid}, 32'h1);
    tick();
    chk("ar_restart_next", out_pc, 32'h4);
    chk("ar_restart_count", fetch_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
